// File: rtl/jpeg_stream_sequencer.sv
// Frame-level sequencer for the JPEG byte stream: header words from the LUT ROM,
// then entropy words from the bit packer, then the EOI marker, onto one output register.
module jpeg_stream_sequencer #(
    parameter int HDR_BYTES = 623,
    parameter int HDR_AW    = 8,
    parameter int CNT_W     = 20
) (
    input  logic              clk,
    input  logic              resetn,
    input  logic              start,
    output logic              busy,
    output logic              done,
    output logic [CNT_W-1:0]  byte_count,
    output logic [HDR_AW-1:0] hdr_addr,
    input  logic [31:0]       hdr_data,
    input  logic [31:0]       in_data,
    input  logic [2:0]        in_nbytes,
    input  logic              in_tlast,
    input  logic              in_valid,
    output logic              in_hold,
    output logic [31:0]       out_data,
    output logic [2:0]        out_nbytes,
    output logic              out_tlast,
    output logic              out_valid,
    input  logic              out_hold
);

    localparam int                HDR_WORDS = (HDR_BYTES + 3) / 4;
    localparam logic [HDR_AW-1:0] LAST_IDX  = HDR_AW'(HDR_WORDS - 1);
    localparam logic [HDR_AW-1:0] IDX_ONE   = HDR_AW'(1);
    localparam logic [2:0]        LAST_NB   = 3'(HDR_BYTES - 4 * (HDR_WORDS - 1));
    localparam logic [31:0]       EOI_WORD  = 32'hFFD9_0000;

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_HEADER = 3'd1,
        S_DATA   = 3'd2,
        S_EOI    = 3'd3,
        S_DRAIN  = 3'd4
    } state_t;

    state_t            state_q, state_d;
    logic [HDR_AW-1:0] word_idx_q, word_idx_d;
    logic [31:0]       out_data_q, out_data_d;
    logic [2:0]        out_nbytes_q, out_nbytes_d;
    logic              out_tlast_q, out_tlast_d;
    logic              out_valid_q, out_valid_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              in_hold_s;
    logic              ld_s;
    logic              xfer_s;
    logic [CNT_W:0]    cnt_sum_s;

    assign ld_s      = ~out_valid_q | ~out_hold;
    assign xfer_s    = out_valid_q & ~out_hold;
    assign cnt_sum_s = {1'b0, cnt_q} + {{(CNT_W - 2){1'b0}}, out_nbytes_q};

    // Next-state and output-register load decisions for the frame sequence.
    always_comb begin
        state_d      = state_q;
        word_idx_d   = word_idx_q;
        out_data_d   = out_data_q;
        out_nbytes_d = out_nbytes_q;
        out_tlast_d  = out_tlast_q;
        out_valid_d  = out_valid_q;
        busy_d       = busy_q;
        done_d       = 1'b0;
        cnt_d        = cnt_q;
        in_hold_s    = 1'b1;

        if (xfer_s) begin
            cnt_d = cnt_sum_s[CNT_W] ? {CNT_W{1'b1}} : cnt_sum_s[CNT_W-1:0];
        end else begin
            cnt_d = cnt_q;
        end

        // An open register slot empties unless a state below refills it.
        if (ld_s) begin
            out_valid_d = 1'b0;
        end else begin
            out_valid_d = out_valid_q;
        end

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d    = S_HEADER;
                    word_idx_d = {HDR_AW{1'b0}};
                    cnt_d      = {CNT_W{1'b0}};
                    busy_d     = 1'b1;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_HEADER: begin
                if (ld_s) begin
                    out_data_d   = hdr_data;
                    out_nbytes_d = (word_idx_q == LAST_IDX) ? LAST_NB : 3'd4;
                    out_tlast_d  = 1'b0;
                    out_valid_d  = 1'b1;
                    if (word_idx_q == LAST_IDX) begin
                        word_idx_d = {HDR_AW{1'b0}};
                        state_d    = S_DATA;
                    end else begin
                        word_idx_d = word_idx_q + IDX_ONE;
                    end
                end else begin
                    word_idx_d = word_idx_q;
                end
            end
            S_DATA: begin
                in_hold_s = ~ld_s;
                if (ld_s && in_valid) begin
                    out_data_d   = in_data;
                    out_nbytes_d = in_nbytes;
                    out_tlast_d  = 1'b0;
                    // Empty words are swallowed so only real bytes reach the writer.
                    out_valid_d  = (in_nbytes != 3'd0);
                    if (in_tlast) begin
                        state_d = S_EOI;
                    end else begin
                        state_d = S_DATA;
                    end
                end else begin
                    state_d = S_DATA;
                end
            end
            S_EOI: begin
                if (ld_s) begin
                    out_data_d   = EOI_WORD;
                    out_nbytes_d = 3'd2;
                    out_tlast_d  = 1'b1;
                    out_valid_d  = 1'b1;
                    state_d      = S_DRAIN;
                end else begin
                    state_d = S_EOI;
                end
            end
            S_DRAIN: begin
                if (xfer_s) begin
                    done_d      = 1'b1;
                    busy_d      = 1'b0;
                    out_tlast_d = 1'b0;
                    state_d     = S_IDLE;
                end else begin
                    state_d = S_DRAIN;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // State and registered outputs, synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            state_q      <= S_IDLE;
            word_idx_q   <= {HDR_AW{1'b0}};
            out_data_q   <= 32'h0000_0000;
            out_nbytes_q <= 3'd0;
            out_tlast_q  <= 1'b0;
            out_valid_q  <= 1'b0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            cnt_q        <= {CNT_W{1'b0}};
        end else begin
            state_q      <= state_d;
            word_idx_q   <= word_idx_d;
            out_data_q   <= out_data_d;
            out_nbytes_q <= out_nbytes_d;
            out_tlast_q  <= out_tlast_d;
            out_valid_q  <= out_valid_d;
            busy_q       <= busy_d;
            done_q       <= done_d;
            cnt_q        <= cnt_d;
        end
    end

    assign busy       = busy_q;
    assign done       = done_q;
    assign byte_count = cnt_q;
    assign hdr_addr   = word_idx_q;
    assign in_hold    = in_hold_s;
    assign out_data   = out_data_q;
    assign out_nbytes = out_nbytes_q;
    assign out_tlast  = out_tlast_q;
    assign out_valid  = out_valid_q;

endmodule

// File: tb/tb_jpeg_stream_sequencer.sv
// Directed bench for jpeg_stream_sequencer with a 10-byte header ROM and
// hand-built expected word sequences.
module tb_jpeg_stream_sequencer;

    localparam int HB = 10;
    localparam int AW = 8;
    localparam int CW = 20;
    localparam int HW = (HB + 3) / 4;

    logic          clk = 1'b0;
    logic          resetn;
    logic          start;
    logic          busy;
    logic          done;
    logic [CW-1:0] byte_count;
    logic [AW-1:0] hdr_addr;
    logic [31:0]   hdr_data;
    logic [31:0]   in_data;
    logic [2:0]    in_nbytes;
    logic          in_tlast;
    logic          in_valid;
    logic          in_hold;
    logic [31:0]   out_data;
    logic [2:0]    out_nbytes;
    logic          out_tlast;
    logic          out_valid;
    logic          out_hold;

    jpeg_stream_sequencer #(.HDR_BYTES(HB), .HDR_AW(AW), .CNT_W(CW)) dut (
        .clk(clk), .resetn(resetn), .start(start), .busy(busy), .done(done),
        .byte_count(byte_count), .hdr_addr(hdr_addr), .hdr_data(hdr_data),
        .in_data(in_data), .in_nbytes(in_nbytes), .in_tlast(in_tlast),
        .in_valid(in_valid), .in_hold(in_hold), .out_data(out_data),
        .out_nbytes(out_nbytes), .out_tlast(out_tlast), .out_valid(out_valid),
        .out_hold(out_hold)
    );

    always #5 clk = ~clk;

    // Header ROM model: word n reads back as C0DE00nn.
    assign hdr_data = 32'hC0DE_0000 | {24'h000000, hdr_addr};

    int            n_vec = 0;
    int            n_err = 0;
    logic [35:0]   obs_q[$];
    logic [35:0]   exp_q[$];
    int            cyc = 0;
    int            eoi_cyc = -1;
    int            done_cyc = -1;
    int            done_cnt = 0;
    logic [CW-1:0] cnt_at_done;
    logic          busy_at_done;
    logic [31:0]   wd[4];
    logic [2:0]    wn[4];
    logic          wt[4];
    bit            frame_over;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Output monitor: logs every transfer and the done pulse, sampled mid-cycle.
    initial begin
        forever begin
            @(negedge clk);
            cyc++;
            if (out_valid && !out_hold) begin
                obs_q.push_back({out_tlast, out_nbytes, out_data});
                if (out_tlast) eoi_cyc = cyc;
            end
            if (done) begin
                done_cnt++;
                done_cyc     = cyc;
                cnt_at_done  = byte_count;
                busy_at_done = busy;
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL global_timeout: got timeout expected finish");
        $fatal(1, "bench did not finish");
    end

    task automatic clr_mon();
        obs_q.delete();
        eoi_cyc  = -1;
        done_cyc = -1;
        done_cnt = 0;
    endtask

    task automatic send_word(input logic [31:0] d, input logic [2:0] nb, input logic tl,
                             input bit chk_hold, output int waited);
        int k;
        waited    = 0;
        in_valid  = 1'b1;
        in_data   = d;
        in_nbytes = nb;
        in_tlast  = tl;
        for (k = 0; k < 100; k++) begin
            @(negedge clk);
            if (chk_hold) check("in_hold_data", {63'd0, in_hold}, {63'd0, out_valid & out_hold});
            if (!in_hold) break;
            waited++;
        end
        if (k == 100) check("in_accept_timeout", 64'd0, 64'd1);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        in_tlast = 1'b0;
    endtask

    task automatic run_frame(input string tag, input bit tog, input bit mid_start, input int nw);
        int waited;
        int exp_bytes;
        int nb;
        clr_mon();
        exp_q.delete();
        exp_bytes = 0;
        for (int i = 0; i < HW; i++) begin
            nb = (HB - 4 * i >= 4) ? 4 : HB - 4 * i;
            exp_q.push_back({1'b0, 3'(nb), 32'hC0DE_0000 | i});
            exp_bytes += nb;
        end
        for (int i = 0; i < nw; i++) begin
            if (wn[i] != 3'd0) begin
                exp_q.push_back({1'b0, wn[i], wd[i]});
                exp_bytes += int'(wn[i]);
            end
        end
        exp_q.push_back({1'b1, 3'd2, 32'hFFD9_0000});
        exp_bytes += 2;

        frame_over = 1'b0;
        out_hold   = 1'b0;
        in_valid   = 1'b1;
        in_data    = wd[0];
        in_nbytes  = wn[0];
        in_tlast   = wt[0];
        @(negedge clk);
        check({tag, "_idle_in_hold"}, {63'd0, in_hold}, 64'd1);
        @(posedge clk); #1 start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
        fork
            begin
                if (tog) begin
                    while (!frame_over) begin
                        @(posedge clk); #1;
                        out_hold = ~out_hold;
                    end
                    out_hold = 1'b0;
                end
            end
            begin
                for (int i = 0; i < nw; i++) begin
                    if (mid_start && i == nw - 1) start = 1'b1;
                    send_word(wd[i], wn[i], wt[i], tog && i > 0, waited);
                    start = 1'b0;
                    if (i == 0 && !tog) check({tag, "_hdr_stall"}, 64'(waited), 64'(HW));
                    if (i == 0) check({tag, "_busy"}, {63'd0, busy}, 64'd1);
                end
                for (int k = 0; k < 200; k++) begin
                    @(negedge clk);
                    if (done_cnt > 0) break;
                end
                if (done_cnt == 0) check({tag, "_done_timeout"}, 64'd0, 64'd1);
                repeat (4) @(negedge clk);
                frame_over = 1'b1;
            end
        join
        check({tag, "_nwords"}, 64'(obs_q.size()), 64'(exp_q.size()));
        for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++)
            check({tag, "_word"}, {28'd0, obs_q[i]}, {28'd0, exp_q[i]});
        check({tag, "_done_cnt"}, 64'(done_cnt), 64'd1);
        check({tag, "_done_lat"}, 64'(done_cyc), 64'(eoi_cyc + 1));
        check({tag, "_cnt_at_done"}, 64'(cnt_at_done), 64'(exp_bytes));
        check({tag, "_busy_at_done"}, {63'd0, busy_at_done}, 64'd0);
        check({tag, "_cnt_hold"}, 64'(byte_count), 64'(exp_bytes));
    endtask

    initial begin
        int waited;
        resetn    = 1'b0;
        start     = 1'b0;
        in_valid  = 1'b0;
        in_data   = 32'h0;
        in_nbytes = 3'd0;
        in_tlast  = 1'b0;
        out_hold  = 1'b0;
        repeat (3) @(posedge clk);
        #1 resetn = 1'b1;
        @(negedge clk);
        check("rst_out_valid", {63'd0, out_valid}, 64'd0);
        check("rst_out_tlast", {63'd0, out_tlast}, 64'd0);
        check("rst_out_nbytes", 64'(out_nbytes), 64'd0);
        check("rst_out_data", 64'(out_data), 64'd0);
        check("rst_busy", {63'd0, busy}, 64'd0);
        check("rst_done", {63'd0, done}, 64'd0);
        check("rst_byte_count", 64'(byte_count), 64'd0);
        check("rst_in_hold", {63'd0, in_hold}, 64'd1);
        check("rst_hdr_addr", 64'(hdr_addr), 64'd0);

        // Basic frame, no back-pressure.
        wd[0] = 32'hAABB_CCDD; wn[0] = 3'd4; wt[0] = 1'b0;
        wd[1] = 32'h1122_0000; wn[1] = 3'd2; wt[1] = 1'b1;
        run_frame("basic", 1'b0, 1'b0, 2);

        // Same stream with toggling downstream stall.
        run_frame("hold", 1'b1, 1'b0, 2);

        // Empty tlast word: EOI directly after header.
        wd[0] = 32'h1234_5678; wn[0] = 3'd0; wt[0] = 1'b1;
        run_frame("empty", 1'b0, 1'b0, 1);

        // start pulse during DATA is ignored.
        wd[0] = 32'hAABB_CCDD; wn[0] = 3'd4; wt[0] = 1'b0;
        wd[1] = 32'h5566_7700; wn[1] = 3'd3; wt[1] = 1'b1;
        run_frame("midstart", 1'b0, 1'b1, 2);
        repeat (6) @(negedge clk);
        check("midstart_idle_busy", {63'd0, busy}, 64'd0);
        check("midstart_no_restart", 64'(done_cnt), 64'd1);

        // Reset mid-DATA with a held word in the output register.
        clr_mon();
        out_hold = 1'b0;
        @(posedge clk); #1 start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
        send_word(32'hAABB_CCDD, 3'd4, 1'b0, 1'b0, waited);
        out_hold = 1'b1;
        @(negedge clk);
        check("rstmid_pre_valid", {63'd0, out_valid}, 64'd1);
        check("rstmid_pre_cnt", 64'(byte_count), 64'(HB));
        @(posedge clk); #1 resetn = 1'b0;
        @(posedge clk); #1 resetn = 1'b1;
        out_hold = 1'b0;
        @(negedge clk);
        check("rstmid_out_valid", {63'd0, out_valid}, 64'd0);
        check("rstmid_busy", {63'd0, busy}, 64'd0);
        check("rstmid_cnt", 64'(byte_count), 64'd0);
        check("rstmid_in_hold", {63'd0, in_hold}, 64'd1);
        check("rstmid_hdr_addr", 64'(hdr_addr), 64'd0);
        wd[0] = 32'hAABB_CCDD; wn[0] = 3'd4; wt[0] = 1'b0;
        wd[1] = 32'h1122_0000; wn[1] = 3'd2; wt[1] = 1'b1;
        run_frame("restart", 1'b0, 1'b0, 2);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
